// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter and one-access sequencer for the single-port 512x16 memory_unit.
// A granted request is latched, driven to memory for one cycle, then acked with registered data.
module mem_port_arbiter #(
  parameter int unsigned AW         = 9,
  parameter int unsigned DW         = 16,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic          l_sel;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          last;

  logic          cand0_c;
  logic          cand1_c;
  logic          grant_c;
  logic          grant_id_c;
  logic          g_we_c;
  logic [AW-1:0] g_addr_c;
  logic [DW-1:0] g_wdata_c;

  // Arbitration: in RESP the requester being acked is not a candidate.
  always_comb begin
    cand0_c    = 1'b0;
    cand1_c    = 1'b0;
    grant_c    = 1'b0;
    grant_id_c = 1'b0;
    if (state != ACCESS) begin
      cand0_c = req0 && !(state == RESP && l_sel == 1'b0);
      cand1_c = req1 && !(state == RESP && l_sel == 1'b1);
    end
    grant_c = cand0_c | cand1_c;
    if (cand0_c && cand1_c) begin
      grant_id_c = FIXED_PRIO ? 1'b0 : ~last;
    end else begin
      grant_id_c = cand1_c;
    end
  end

  assign g_we_c    = grant_id_c ? we1    : we0;
  assign g_addr_c  = grant_id_c ? addr1  : addr0;
  assign g_wdata_c = grant_id_c ? wdata1 : wdata0;

  // Memory address/data come straight from the latch registers, so they hold outside ACCESS.
  assign mem_addr = l_addr;
  assign mem_d    = l_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      l_sel   <= 1'b0;
      l_we    <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      last    <= 1'b1;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        IDLE, RESP: begin
          if (grant_c) begin
            state   <= ACCESS;
            l_sel   <= grant_id_c;
            last    <= grant_id_c;
            l_we    <= g_we_c;
            l_addr  <= g_addr_c;
            l_wdata <= g_wdata_c;
            mem_we  <= g_we_c;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ACCESS: begin
          // Write commits in memory at this edge; a read captures the combinational q.
          if (!l_we) begin
            if (l_sel) begin
              rdata1 <= mem_q;
            end else begin
              rdata0 <= mem_q;
            end
          end
          ack0  <= ~l_sel;
          ack1  <= l_sel;
          busy  <= 1'b1;
          state <= RESP;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-timeline reference model
// and a behavioural stand-in for memory_unit.
module tb_mem_port_arbiter;

  localparam int unsigned AW         = 9;
  localparam int unsigned DW         = 16;
  localparam bit          FIXED_PRIO = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [1:0]    we  = 2'b00;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          ack0, ack1, mem_we, busy;
  logic [DW-1:0] rdata0, rdata1, mem_d, mem_q;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(FIXED_PRIO)) dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'((a * 1103) ^ 32'h5A5A);
  endfunction

  // memory_unit stand-in: combinational read, write on rising edge
  logic [DW-1:0] mem_arr [512];
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) mem_arr[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (mem_we) begin
      mem_arr[mem_addr] <= mem_d;
    end
  end
  assign mem_q = mem_arr[mem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a grant at edge E gives an access window E..E+1 and an ack E+1..E+2;
  // the next arbitration is at E+2 (acked requester excluded) or any later idle edge.
  logic [DW-1:0] shadow [512];
  logic [DW-1:0] exp_rdata [2];
  int            edge_n = 0;
  int            g_edge;
  logic          g_id, g_we, last_id;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic [1:0]    granted;
  logic [1:0]    exp_ack;
  logic          exp_busy, exp_mem_we;

  task automatic model_reset();
    g_edge = edge_n - 100;
    g_id = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;
    last_id = 1'b1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    granted = 2'b00; exp_ack = 2'b00; exp_busy = 1'b0; exp_mem_we = 1'b0;
  endtask

  task automatic model_edge();
    int   d;
    logic c0, c1, g;
    edge_n++;
    d = edge_n - g_edge;
    if (d == 1) begin
      if (g_we) shadow[g_addr] = g_wdata;
      else exp_rdata[g_id] = shadow[g_addr];
    end
    if (d >= 2) begin
      c0 = req[0] && !(d == 2 && g_id == 1'b0);
      c1 = req[1] && !(d == 2 && g_id == 1'b1);
      if (c0 || c1) begin
        if (c0 && c1) g = FIXED_PRIO ? 1'b0 : !last_id;
        else g = c1;
        g_edge = edge_n; g_id = g; g_we = we[g]; g_addr = addr[g]; g_wdata = wdata[g];
        last_id = g; granted[g] = 1'b1;
      end
    end
    d = edge_n - g_edge;
    exp_busy   = (d <= 1);
    exp_mem_we = (d == 0) && g_we;
    exp_ack[0] = (d == 1) && !g_id;
    exp_ack[1] = (d == 1) && g_id;
  endtask

  int cyc = 0;
  int we_cnt = 0;
  int ack_cyc [2];
  int ack_log_id [$];
  int ack_log_cyc [$];

  // One clock: model advances over the edge, DUT outputs checked on the falling edge.
  task automatic cycle_step();
    model_edge();
    @(negedge clk);
    cyc++;
    check("ack0",     32'(ack0),     32'(exp_ack[0]));
    check("ack1",     32'(ack1),     32'(exp_ack[1]));
    check("busy",     32'(busy),     32'(exp_busy));
    check("mem_we",   32'(mem_we),   32'(exp_mem_we));
    check("mem_addr", 32'(mem_addr), 32'(g_addr));
    check("mem_d",    32'(mem_d),    32'(g_wdata));
    check("rdata0",   32'(rdata0),   32'(exp_rdata[0]));
    check("rdata1",   32'(rdata1),   32'(exp_rdata[1]));
    if (mem_we) we_cnt++;
    if (ack0) begin ack_cyc[0] = cyc; ack_log_id.push_back(0); ack_log_cyc.push_back(cyc); end
    if (ack1) begin ack_cyc[1] = cyc; ack_log_id.push_back(1); ack_log_cyc.push_back(cyc); end
  endtask

  task automatic raise(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(3) == 0) return AW'($urandom);
    return AW'($urandom_range(15));
  endfunction

  // Requester behaviour: drop on ack, occasionally abandon an ungranted request, raise new ones.
  task automatic env_react(input int raise_pct, input int drop_pct);
    for (int i = 0; i < 2; i++) begin
      if (exp_ack[i]) begin
        req[i] = 1'b0; granted[i] = 1'b0;
      end else if (req[i] && !granted[i] && int'($urandom_range(99)) < drop_pct) begin
        req[i] = 1'b0;
      end
      if (!req[i] && int'($urandom_range(99)) < raise_pct)
        raise(i, 1'($urandom_range(1)), rand_addr(), DW'($urandom));
    end
  endtask

  task automatic run_quiet(input int budget);
    int n = 0;
    while ((req != 2'b00 || exp_busy) && n < budget) begin
      cycle_step();
      env_react(0, 0);
      n++;
    end
    if (req != 2'b00 || exp_busy) check("drain_timeout", 32'(n), 32'(budget + 1));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ack0"},     32'(ack0),     32'h0);
    check({pfx, "_ack1"},     32'(ack1),     32'h0);
    check({pfx, "_busy"},     32'(busy),     32'h0);
    check({pfx, "_mem_we"},   32'(mem_we),   32'h0);
    check({pfx, "_mem_addr"}, 32'(mem_addr), 32'h0);
    check({pfx, "_mem_d"},    32'(mem_d),    32'h0);
    check({pfx, "_rdata0"},   32'(rdata0),   32'h0);
    check({pfx, "_rdata1"},   32'(rdata1),   32'h0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    req = 2'b00;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    int k, n, acks1;
    logic [1:0] just;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    for (int i = 0; i < 512; i++) shadow[i] = init_word(i);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check_reset_outputs("reset");

    // Single write then read by requester 0
    ack_cyc[0] = -1; we_cnt = 0; k = cyc;
    raise(0, 1'b1, AW'(9'h1A3), DW'(16'hBEEF));
    run_quiet(20);
    check("wr_latency", 32'(ack_cyc[0] - k), 32'd2);
    check("wr_we_pulses", 32'(we_cnt), 32'd1);
    raise(0, 1'b0, AW'(9'h1A3), DW'(16'h0000));
    run_quiet(20);
    check("rd_rdata0", 32'(rdata0), 32'hBEEF);
    check("rd_rdata1", 32'(rdata1), 32'h0);

    // Tie straight out of reset: requester 0 first, requester 1 two cycles later
    do_reset();
    k = ack_log_id.size();
    raise(1, 1'b0, AW'(0), DW'(0));
    raise(0, 1'b1, AW'(1), DW'(16'h1234));
    run_quiet(20);
    check("tie_acks", 32'(ack_log_id.size() - k), 32'd2);
    if (ack_log_id.size() >= k + 2) begin
      check("tie_first",  32'(ack_log_id[k]), 32'd0);
      check("tie_second", 32'(ack_log_id[k+1]), 32'd1);
      check("tie_gap",    32'(ack_log_cyc[k+1] - ack_log_cyc[k]), 32'd2);
    end
    check("tie_rdata1", 32'(rdata1), 32'(init_word(0)));

    // Continuous contention, each requester re-raising the cycle after its ack
    k = ack_log_id.size(); n = 0; just = 2'b00;
    while (ack_log_id.size() < k + 8 && n < 60) begin
      for (int i = 0; i < 2; i++)
        if (!req[i] && !just[i]) raise(i, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
      cycle_step();
      for (int i = 0; i < 2; i++) begin
        just[i] = exp_ack[i];
        if (exp_ack[i]) begin req[i] = 1'b0; granted[i] = 1'b0; end
      end
      n++;
    end
    check("cont_count", 32'(ack_log_id.size() - k), 32'd8);
    for (int j = 0; j < 8 && k + j < ack_log_id.size(); j++) begin
      check("cont_order", 32'(ack_log_id[k+j]), 32'(j % 2));
      if (j > 0) check("cont_gap", 32'(ack_log_cyc[k+j] - ack_log_cyc[k+j-1]), 32'd2);
    end
    run_quiet(40);

    // Requester 1 writes, requester 0 reads the same word
    raise(1, 1'b1, AW'(9'h0FE), DW'(16'h00FF));
    run_quiet(20);
    raise(0, 1'b0, AW'(9'h0FE), DW'(0));
    run_quiet(20);
    check("xread_rdata0", 32'(rdata0), 32'h00FF);

    // Reset during the ACCESS cycle of a write: no ack, memory keeps its old word
    k = ack_log_id.size();
    raise(1, 1'b1, AW'(9'h010), DW'(16'hAAAA));
    cycle_step();
    do_reset();
    raise(0, 1'b0, AW'(9'h010), DW'(0));
    run_quiet(20);
    acks1 = 0;
    for (int j = k; j < ack_log_id.size(); j++) if (ack_log_id[j] == 1) acks1++;
    check("rst_cut_no_ack1", 32'(acks1), 32'd0);
    check("rst_cut_rdata0", 32'(rdata0), 32'(init_word(16)));

    // Randomized traffic at increasing load, with one reset in the middle
    for (int seg = 0; seg < 3; seg++) begin
      for (int c = 0; c < 600; c++) begin
        if (seg == 1 && c == 300) do_reset();
        cycle_step();
        env_react(seg == 0 ? 20 : (seg == 1 ? 60 : 100), 5);
      end
    end
    run_quiet(50);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
